// File: rtl/theta_encoder.sv
// Angle (degrees) to code = round(N*cos(theta)) via rotation-mode CORDIC; optional range_err port with THETA_ENC_RANGE_EN.
// Latency: code_valid rises ITERS+3 cycles after the theta handshake.
// Backpressure: single conversion in flight; theta_ready low while busy, code held until code_ready.
module theta_encoder #(
    parameter int N     = 87,
    parameter int ITERS = 14,
    parameter int W     = 18
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic [7:0] theta,
    input  logic       theta_valid,
    output logic       theta_ready,
    output logic [7:0] code,
    output logic       code_valid,
    input  logic       code_ready
`ifdef THETA_ENC_RANGE_EN
    ,
    output logic       range_err
`endif
);

    typedef enum logic [2:0] {IDLE, LOAD, ITER, SCALE, DONE} state_t;

    state_t              state;
    logic [7:0]          theta_q;
    logic signed [W-1:0] x, y, z;
    logic [4:0]          i;
    logic                oor;

    logic [W-1:0]        z_load;
    logic signed [31:0]  x_ext, prod, c;
    logic [7:0]          code_next;

    // round(atan(2^-i) * 2^14)
    function automatic logic signed [W-1:0] atan_lut(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_lut = W'(12868);
            5'd1:    atan_lut = W'(7596);
            5'd2:    atan_lut = W'(4014);
            5'd3:    atan_lut = W'(2037);
            5'd4:    atan_lut = W'(1023);
            5'd5:    atan_lut = W'(512);
            5'd6:    atan_lut = W'(256);
            5'd7:    atan_lut = W'(128);
            5'd8:    atan_lut = W'(64);
            5'd9:    atan_lut = W'(32);
            5'd10:   atan_lut = W'(16);
            5'd11:   atan_lut = W'(8);
            5'd12:   atan_lut = W'(4);
            5'd13:   atan_lut = W'(2);
            5'd14:   atan_lut = W'(1);
            default: atan_lut = '0;
        endcase
    endfunction

    assign z_load = W'(theta_q) * W'(286);
    assign x_ext  = 32'(x);
    assign prod   = x_ext * 32'(N) + 32'sd8192;
    assign c      = prod >>> 14;

    always_comb begin
        code_next = '0;
        if (oor || c < 0)
            code_next = '0;
        else if (c > 32'(N))
            code_next = 8'(N);
        else
            code_next = 8'(c);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            theta_ready <= 1'b1;
            code        <= '0;
            code_valid  <= 1'b0;
            theta_q     <= '0;
            x           <= '0;
            y           <= '0;
            z           <= '0;
            i           <= '0;
            oor         <= 1'b0;
`ifdef THETA_ENC_RANGE_EN
            range_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (theta_valid) begin
                        theta_q     <= theta;
                        theta_ready <= 1'b0;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    z     <= signed'(z_load);
                    x     <= W'(9949);
                    y     <= '0;
                    i     <= '0;
                    oor   <= (theta_q > 8'd90);
                    state <= ITER;
                end
                ITER: begin
                    if (z >= 0) begin
                        x <= x - (y >>> i);
                        y <= y + (x >>> i);
                        z <= z - atan_lut(i);
                    end else begin
                        x <= x + (y >>> i);
                        y <= y - (x >>> i);
                        z <= z + atan_lut(i);
                    end
                    i <= i + 5'd1;
                    if (i == 5'(ITERS - 1))
                        state <= SCALE;
                end
                SCALE: begin
                    code  <= code_next;
                    state <= DONE;
                end
                DONE: begin
                    // First DONE cycle raises valid; acceptance only counts once valid is visible.
                    if (!code_valid) begin
                        code_valid <= 1'b1;
`ifdef THETA_ENC_RANGE_EN
                        range_err  <= oor;
`endif
                    end else if (code_ready) begin
                        code_valid  <= 1'b0;
                        theta_ready <= 1'b1;
                        state       <= IDLE;
`ifdef THETA_ENC_RANGE_EN
                        range_err   <= 1'b0;
`endif
                    end
                end
                default: begin
                    state       <= IDLE;
                    theta_ready <= 1'b1;
                    code_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule
